i2c_slave_regbank: RTL and testbench

- Next-generation I2C slave: supports both write and read transfers against an application register space of DEPTH bytes.
- The first byte of a write is taken as a register pointer. The pointer auto-increments per data byte.
- Register storage stays in the application. This block issues write strobes and samples read data through a simple local port.
- Sits between the chip I2C pads (open-drain, pad-side tristate) and the control/status register logic.

---
 rtl/i2c_slave_regbank.sv | 242 ++++++++++++++++++++++++
 tb/tb_i2c_slave_regbank.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regbank.sv
// I2C slave front end for a byte register space: pointer byte, then writes or reads with auto-increment.
// Optional general-call support is enabled by defining I2C_SLV_GEN_CALL_EN.
module i2c_slave_regbank #(
  parameter logic [6:0]  SLAVE_ADDRESS = 7'h21,
  parameter int unsigned DEPTH         = 16,
  localparam int         PTR_W         = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             scl_o,
  output logic             sda_o,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic [PTR_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             busy,
  output logic             gcall
);

`ifdef I2C_SLV_GEN_CALL_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  // state    | meaning
  // IDLE     | waiting for START
  // ADDR     | shifting in 7-bit address + R/W
  // ADDR_ACK | acknowledging our address
  // PTR      | receiving register pointer byte
  // WR       | receiving data bytes (or general-call bytes)
  // RD       | transmitting data bytes, sampling master ACK
  // WAIT     | bus released until STOP/START
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_WR, S_RD, S_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             sda_o_q, sda_o_d;
  logic             wr_valid_q, wr_valid_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             busy_q, busy_d;
  logic             gcall_q, gcall_d;
  logic             rw_q, rw_d;
  logic             gc_q, gc_d;
  logic             mack_q, mack_d;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
  assign start_det = ~sda_sync_q[1] & sda_sync_q[2] & scl_sync_q[1];
  assign stop_det  = sda_sync_q[1] & ~sda_sync_q[2] & scl_sync_q[1];
  assign rx_byte   = {shift_q[6:0], sda_sync_q[1]};

  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], scl_i};
    sda_sync_d = {sda_sync_q[1:0], sda_i};
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_o_d    = sda_o_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    gcall_d    = 1'b0;
    rw_d       = rw_q;
    gc_d       = gc_q;
    mack_d     = mack_q;

    if (stop_det) begin
      state_d   = S_IDLE;
      bit_cnt_d = 4'd0;
      sda_o_d   = 1'b1;
      busy_d    = 1'b0;
      mack_d    = 1'b0;
    end else if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      sda_o_d   = 1'b1;
      busy_d    = 1'b0;
      mack_d    = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q != 4'd7) begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (rx_byte[7:1] == SLAVE_ADDRESS) begin
              state_d   = S_ADDR_ACK;
              bit_cnt_d = 4'd8;
              busy_d    = 1'b1;
              rw_d      = rx_byte[0];
              gc_d      = 1'b0;
            end else if (GC_EN && rx_byte == 8'h00) begin
              state_d   = S_ADDR_ACK;
              bit_cnt_d = 4'd8;
              busy_d    = 1'b1;
              rw_d      = 1'b0;
              gc_d      = 1'b1;
            end else begin
              state_d   = S_IDLE;
              bit_cnt_d = 4'd0;
            end
          end
        end
        S_ADDR_ACK: begin
          // first fall drives the ACK, second fall ends the slot
          if (scl_fall) begin
            if (sda_o_q) begin
              sda_o_d = 1'b0;
            end else if (rw_q) begin
              state_d   = S_RD;
              bit_cnt_d = 4'd0;
              shift_d   = rd_data;
              sda_o_d   = rd_data[7];
              ptr_d     = ptr_q + 1'b1;
              mack_d    = 1'b0;
            end else begin
              state_d   = gc_q ? S_WR : S_PTR;
              bit_cnt_d = 4'd0;
              sda_o_d   = 1'b1;
            end
          end
        end
        S_PTR, S_WR: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == S_PTR) begin
                ptr_d = rx_byte[PTR_W-1:0];
              end else if (gc_q) begin
                gcall_d   = 1'b1;
                wr_data_d = rx_byte;
              end else begin
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = rx_byte;
                ptr_d      = ptr_q + 1'b1;
              end
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (sda_o_q) begin
              sda_o_d = 1'b0;
            end else begin
              sda_o_d   = 1'b1;
              bit_cnt_d = 4'd0;
              state_d   = S_WR;
            end
          end
        end
        S_RD: begin
          if (scl_rise) begin
            if (bit_cnt_q < 4'd8) begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (sda_sync_q[1]) begin
              state_d   = S_WAIT;
              bit_cnt_d = 4'd0;
            end else begin
              mack_d = 1'b1;
            end
          end else if (scl_fall) begin
            if (bit_cnt_q >= 4'd1 && bit_cnt_q <= 4'd7) begin
              sda_o_d = shift_q[6];
              shift_d = {shift_q[6:0], 1'b0};
            end else if (bit_cnt_q == 4'd8) begin
              if (mack_q) begin
                shift_d   = rd_data;
                sda_o_d   = rd_data[7];
                ptr_d     = ptr_q + 1'b1;
                bit_cnt_d = 4'd0;
                mack_d    = 1'b0;
              end else begin
                sda_o_d = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      ptr_q      <= '0;
      sda_o_q    <= 1'b1;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      gcall_q    <= 1'b0;
      rw_q       <= 1'b0;
      gc_q       <= 1'b0;
      mack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_o_q    <= sda_o_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      gcall_q    <= gcall_d;
      rw_q       <= rw_d;
      gc_q       <= gc_d;
      mack_q     <= mack_d;
    end
  end

  assign scl_o    = 1'b1;
  assign sda_o    = sda_o_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_addr  = ptr_q;
  assign busy     = busy_q;
  assign gcall    = gcall_q;

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Bit-banged I2C master driving i2c_slave_regbank; write strobes and general-call pulses go through scoreboards.
`timescale 1ns/1ps
module tb_i2c_slave_regbank;
  localparam int Q = 50;

  logic       clk, rst_n, scl_m, sda_m;
  logic       scl_o, sda_o, wr_valid, busy, gcall;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;
  logic       sda_line, scl_line;

  assign sda_line = sda_m & sda_o;
  assign scl_line = scl_m & scl_o;
  assign rd_data  = 8'hC0 + {4'h0, rd_addr};

  i2c_slave_regbank #(.SLAVE_ADDRESS(7'h21), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_line), .sda_i(sda_line),
    .scl_o(scl_o), .sda_o(sda_o), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .gcall(gcall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dev, ptr, d0, d1;
    logic       ack;
    logic [3:0] a0, a1;
  } vec_t;
  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  int         total, bad, sda_low_cnt;
  wr_t        exp_q[$];
  logic [7:0] gc_exp_q[$];
  vec_t       vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!sda_o) sda_low_cnt++;
    if (rst_n && wr_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_wr_valid: got addr %0h data %0h expected no strobe", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {28'h0, wr_addr}, {28'h0, e.a});
        chk("wr_data", {24'h0, wr_data}, {24'h0, e.d});
      end
    end
    if (rst_n && gcall) begin
      if (gc_exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_gcall: got data %0h expected no pulse", wr_data);
      end else begin
        logic [7:0] g;
        g = gc_exp_q.pop_front();
        chk("gcall_data", {24'h0, wr_data}, {24'h0, g});
      end
    end
  end

  task automatic m_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic m_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic m_bit(input logic b);
    sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) m_bit(b[i]);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; ack = sda_line; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic rbyte(input logic ack_in, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl_m = 1'b1; #Q; b[i] = sda_line; #Q; scl_m = 1'b0;
    end
    #Q; sda_m = ack_in; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
  endtask

  task automatic run_vec(input vec_t v);
    logic ak, pk, k0, k1;
    int   low0;
    low0 = sda_low_cnt;
    m_start();
    wbyte(v.dev, ak);
    chk("addr_ack", {31'h0, ak}, {31'h0, !v.ack});
    wbyte(v.ptr, pk);
    chk("busy_mid", {31'h0, busy}, {31'h0, v.ack});
    if (v.ack) exp_q.push_back(wr_t'{a: v.a0, d: v.d0});
    wbyte(v.d0, k0);
    if (v.ack) exp_q.push_back(wr_t'{a: v.a1, d: v.d1});
    wbyte(v.d1, k1);
    m_stop();
    #(4*Q);
    chk("ptr_ack", {31'h0, pk}, {31'h0, !v.ack});
    chk("d0_ack", {31'h0, k0}, {31'h0, !v.ack});
    chk("d1_ack", {31'h0, k1}, {31'h0, !v.ack});
    chk("busy_after_stop", {31'h0, busy}, 32'h0);
    chk("wr_drained", exp_q.size(), 32'h0);
    if (!v.ack) chk("sda_never_low", sda_low_cnt - low0, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       k;
    logic [7:0] b;
    total = 0; bad = 0; sda_low_cnt = 0;
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    #33;
    chk("rst_sda_o", {31'h0, sda_o}, 32'h1);
    chk("rst_scl_o", {31'h0, scl_o}, 32'h1);
    chk("rst_wr_valid", {31'h0, wr_valid}, 32'h0);
    chk("rst_wr_addr", {28'h0, wr_addr}, 32'h0);
    chk("rst_wr_data", {24'h0, wr_data}, 32'h0);
    chk("rst_rd_addr", {28'h0, rd_addr}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_gcall", {31'h0, gcall}, 32'h0);
    rst_n = 1'b1;
    #100;

    vecs.push_back('{dev: 8'h42, ptr: 8'h03, d0: 8'hA5, d1: 8'h5A, ack: 1'b1, a0: 4'h3, a1: 4'h4});
    vecs.push_back('{dev: 8'h42, ptr: 8'h0F, d0: 8'h11, d1: 8'h22, ack: 1'b1, a0: 4'hF, a1: 4'h0});
    vecs.push_back('{dev: 8'h42, ptr: 8'hF7, d0: 8'h3C, d1: 8'hC3, ack: 1'b1, a0: 4'h7, a1: 4'h8});
    vecs.push_back('{dev: 8'h44, ptr: 8'h11, d0: 8'h99, d1: 8'h88, ack: 1'b0, a0: 4'h0, a1: 4'h0});
    vecs.push_back('{dev: 8'h40, ptr: 8'h02, d0: 8'h77, d1: 8'h66, ack: 1'b0, a0: 4'h0, a1: 4'h0});
    foreach (vecs[i]) run_vec(vecs[i]);

    // repeated-START read continuing from the written pointer, wrapping at DEPTH
    m_start();
    wbyte(8'h42, k); chk("rd_wa_ack", {31'h0, k}, 32'h0);
    wbyte(8'h0E, k); chk("rd_ptr_ack", {31'h0, k}, 32'h0);
    m_start();
    wbyte(8'h43, k); chk("rd_ra_ack", {31'h0, k}, 32'h0);
    rbyte(1'b0, b); chk("rd_byte0", {24'h0, b}, 32'hCE);
    rbyte(1'b0, b); chk("rd_byte1", {24'h0, b}, 32'hCF);
    rbyte(1'b1, b); chk("rd_byte2_wrap", {24'h0, b}, 32'hC0);
    #Q;
    chk("wait_sda_released", {31'h0, sda_o}, 32'h1);
    chk("wait_busy", {31'h0, busy}, 32'h1);
    chk("rd_ptr_after", {28'h0, rd_addr}, 32'h1);
    m_stop(); #(4*Q);
    chk("rd_busy_after_stop", {31'h0, busy}, 32'h0);

    // STOP in the middle of a data byte discards it
    m_start();
    wbyte(8'h42, k); chk("ab_addr_ack", {31'h0, k}, 32'h0);
    wbyte(8'h07, k);
    exp_q.push_back(wr_t'{a: 4'h7, d: 8'h11});
    wbyte(8'h11, k);
    m_bit(1'b1); m_bit(1'b0); m_bit(1'b1); m_bit(1'b1);
    m_stop(); #(4*Q);
    chk("ab_drained", exp_q.size(), 32'h0);
    chk("ab_ptr_kept", {28'h0, rd_addr}, 32'h8);
    m_start();
    wbyte(8'h43, k); chk("ab_rd_ack", {31'h0, k}, 32'h0);
    rbyte(1'b1, b); chk("ab_rd_data", {24'h0, b}, 32'hC8);
    m_stop(); #(4*Q);

    // reset pulse while the slave is pulling SDA low for the address ACK
    b = 8'h42;
    m_start();
    for (int i = 7; i >= 0; i--) m_bit(b[i]);
    sda_m = 1'b1; #Q;
    chk("rs_ack_driven", {31'h0, sda_o}, 32'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rs_sda_released", {31'h0, sda_o}, 32'h1);
    chk("rs_busy", {31'h0, busy}, 32'h0);
    chk("rs_rd_addr", {28'h0, rd_addr}, 32'h0);
    scl_m = 1'b1; #(2*Q);
    rst_n = 1'b1; #(4*Q);
    run_vec('{dev: 8'h42, ptr: 8'h05, d0: 8'hE1, d1: 8'h1E, ack: 1'b1, a0: 4'h5, a1: 4'h6});

`ifdef I2C_SLV_GEN_CALL_EN
    m_start();
    wbyte(8'h00, k); chk("gc_addr_ack", {31'h0, k}, 32'h0);
    gc_exp_q.push_back(8'h06);
    wbyte(8'h06, k); chk("gc_data_ack", {31'h0, k}, 32'h0);
    m_stop(); #(4*Q);
    chk("gc_drained", gc_exp_q.size(), 32'h0);
    chk("gc_ptr_unchanged", {28'h0, rd_addr}, 32'h7);
    m_start();
    wbyte(8'h01, k); chk("gc_read_nack", {31'h0, k}, 32'h1);
    m_stop(); #(4*Q);
`else
    m_start();
    wbyte(8'h00, k); chk("gc_addr_nack", {31'h0, k}, 32'h1);
    wbyte(8'h06, k); chk("gc_data_nack", {31'h0, k}, 32'h1);
    m_stop(); #(4*Q);
`endif
    chk("busy_final", {31'h0, busy}, 32'h0);
    chk("final_wr_drained", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
